famiclone_detect_ctrl: RTL
==========================

// Module: famiclone_detect_ctrl
// PURPOSE
//  Power-on sequencer and detector for PPU-side compatibility. Grounds CIRAM /CE and PPU /A13
//  while the console powers up. Then it samples PPU read cycles and decides whether the host
//  is a classic console or a new-style famiclone (/A13 not the inverse of A13).
//  It drives the ppu_ciram_ce / ppu_not_a13 pad controls used by the CoolGirl top level.
// PARAMETERS
//  HOLD_CYCLES   15  m2 cycles that CIRAM /CE and /A13 are held low after reset/restart (>=1)
//  SETTLE_CYCLES 2   m2 cycles after release before sampling starts (0 allowed = skip)
//  VOTES_LOW     3   qualified read events with A13=0 needed for a decision (>=1)
//  VOTES_HIGH    3   qualified read events with A13=1 needed for a decision (>=1)
//  MISMATCH_MIN  1   mismatching events (a13 == not_a13) needed to declare new famiclone (>=1)
// PORTS
//  m2               in   1  CPU M2, sole clock, rising edge
//  reset            in   1  asynchronous, active-high
//  restart          in   1  sync pulse: re-run full sequence from HOLD
//  ppu_rd_in        in   1  PPU /RD pad, active low
//  ppu_a13_in       in   1  PPU A13 pad
//  ppu_not_a13_in   in   1  PPU /A13 pad, read back
//  ext_ntram_access in   1  four-screen external NT RAM access this cycle (combinational)
//  ciram_ce_oe      out  1  1 = drive ppu_ciram_ce pad with ciram_ce_out; 0 = tri-state
//  ciram_ce_out     out  1  value for ppu_ciram_ce when driven
//  not_a13_drive    out  1  1 = drive ppu_not_a13 pad low; 0 = tri-state
//  new_dendy        out  1  decided: new famiclone
//  detect_done      out  1  decision made (new or classic)
//  state_dbg        out  3  current state encoding
// BEHAVIOUR
//  States: HOLD(0) SETTLE(1) SAMPLE(2) CLASSIC(3) NEWDENDY(4). Reset and restart enter HOLD.
//  Reset values: state HOLD, all counters 0, new_dendy 0, detect_done 0.
//  Reset values: not_a13_drive 1, ciram_ce_oe 1, ciram_ce_out 0.
//  HOLD:
//   - not_a13_drive=1; ciram_ce_oe=1; ciram_ce_out=0.
//   - Cycle counter increments each m2.
//   - After exactly HOLD_CYCLES rising edges in HOLD, go to SETTLE (or SAMPLE if SETTLE_CYCLES=0).
//  SETTLE: not_a13_drive=0. Wait SETTLE_CYCLES edges, then go to SAMPLE.
//  Pad outputs in SETTLE/SAMPLE/CLASSIC: not_a13_drive=0; ciram_ce_oe=1;
//   ciram_ce_out = ext_ntram_access ? 1 : ~ppu_a13_in (combinational).
//  NEWDENDY pad outputs: ciram_ce_oe=0; not_a13_drive=0.
//  Sampler: ppu_rd_in, ppu_a13_in and ppu_not_a13_in are registered on posedge m2 (1 flop stage).
//   - A read event = registered rd was 1 last cycle and 0 now.
//   - The event's A13 and /A13 are taken from the same registered sample.
//   - Events are counted only in SAMPLE.
//  SAMPLE, per event:
//   - a13==not_a13: increment mismatch count.
//   - Otherwise: increment the low or high vote count by A13; each saturates at its target.
//   - mismatch count reaching MISMATCH_MIN -> NEWDENDY next edge.
//   - Else both vote counts at target -> CLASSIC.
//   - If both happen on the same edge, NEWDENDY wins.
//   - No timeout: with rendering off, stay in SAMPLE indefinitely with classic pad behaviour.
//  CLASSIC/NEWDENDY: terminal; detect_done=1; new_dendy=1 only in NEWDENDY.
//   - Leave only via reset or restart.
//  restart takes priority over every transition. On restart: counters clear and the next state is
//   HOLD, so pads are grounded on the following cycle.
//  Reset asserted mid-sequence: immediate async return to reset values, pads grounded.
//  Counter widths: $clog2(max+1). Vote/mismatch counters saturate and never wrap.
//  Latency: pad event to counted = 2 m2 edges.
// STRUCTURE
//  Shared header CoolGirl_famiclone_defs.vh holds:
//   - state localparams (FD_HOLD..FD_NEWDENDY, 3-bit);
//   - default parameter values, shared with the top-level config.
//  Sub-module ppu_rd_event_sampler: input flops plus falling-edge detect.
//   - Outputs: evt, evt_a13, evt_not_a13.
//  FSM and counters live in this module. Top level maps ciram_ce_oe/not_a13_drive to the inout pads.
// TESTING
//  1 Reset, no PPU activity, defaults:
//    - not_a13_drive=1 and ciram_ce_out=0 for exactly 15 m2 edges;
//    - then SETTLE for 2 edges;
//    - state_dbg=2 from edge 18 onward; detect_done stays 0 forever.
//  2 Classic host: events A13=0,/A13=1 x3 and A13=1,/A13=0 x3 ->
//    - state CLASSIC, new_dendy=0, ciram_ce_out tracks ~A13;
//    - ext_ntram_access=1 forces ciram_ce_out=1.
//  3 New famiclone: first event has A13=0,/A13=0 -> NEWDENDY on the next edge;
//    - new_dendy=1; ciram_ce_oe=0; not_a13_drive=0.
//  4 Same edge: votes complete (3/3) and first mismatch together -> NEWDENDY, not CLASSIC.
//  5 Restart pulse in CLASSIC -> state HOLD next edge, pads grounded 15 edges, counters 0.
//    - Repeat detection with mismatch -> NEWDENDY.
//  6 Reset asserted in SAMPLE between clock edges:
//    - outputs return to reset values immediately (async);
//    - rd held low across the release does not count as an event.

Source files
------------

// File: rtl/famiclone_detect_ctrl_pkg.sv
// famiclone_detect_ctrl_pkg
//   Shared definitions for the famiclone detector. It holds:
//   - the state encoding, which is visible on state_dbg;
//   - the default parameter values, which the top-level configuration also uses;
//   - a counter-width helper.
package famiclone_detect_ctrl_pkg;

  typedef enum logic [2:0] {
    FD_HOLD     = 3'd0,
    FD_SETTLE   = 3'd1,
    FD_SAMPLE   = 3'd2,
    FD_CLASSIC  = 3'd3,
    FD_NEWDENDY = 3'd4
  } fd_state_e;

  localparam int FD_HOLD_CYCLES_DEF   = 15;
  localparam int FD_SETTLE_CYCLES_DEF = 2;
  localparam int FD_VOTES_LOW_DEF     = 3;
  localparam int FD_VOTES_HIGH_DEF    = 3;
  localparam int FD_MISMATCH_MIN_DEF  = 1;

  // Width needed to hold 0..max_val. The result is never less than one bit.
  function automatic int fd_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/famiclone_detect_ctrl_if.sv
// famiclone_detect_ctrl_if
//   Groups the PPU pad inputs and the detector outputs.
//   - slave  : the detector side.
//   - master : the side that drives the pads and observes the decision.
//
//   Qualifier semantics:
//   - There is no valid/ready handshake on this bus.
//   - detect_done is a level "valid" for new_dendy. new_dendy is meaningful only
//     while detect_done=1.
//   - The decision holds until reset or restart.
//   - restart is a single-cycle synchronous request and is always accepted.
interface famiclone_detect_ctrl_if;
  logic       restart;
  logic       ppu_rd_in;
  logic       ppu_a13_in;
  logic       ppu_not_a13_in;
  logic       ext_ntram_access;
  logic       ciram_ce_oe;
  logic       ciram_ce_out;
  logic       not_a13_drive;
  logic       new_dendy;
  logic       detect_done;
  logic [2:0] state_dbg;

  modport slave (
    input  restart, ppu_rd_in, ppu_a13_in, ppu_not_a13_in, ext_ntram_access,
    output ciram_ce_oe, ciram_ce_out, not_a13_drive, new_dendy, detect_done, state_dbg
  );

  modport master (
    output restart, ppu_rd_in, ppu_a13_in, ppu_not_a13_in, ext_ntram_access,
    input  ciram_ce_oe, ciram_ce_out, not_a13_drive, new_dendy, detect_done, state_dbg
  );
endinterface

// File: rtl/famiclone_detect_ctrl_sampler.sv
// famiclone_detect_ctrl_sampler
//   Registers the PPU /RD, A13 and /A13 pads in one flop stage and detects
//   falling edges of the registered /RD.
//   Ports:
//     m2, reset          clock (rising edge) and asynchronous active-high reset
//     rd_i               PPU /RD pad, active low
//     a13_i, not_a13_i   PPU A13 and /A13 pads
//     evt_o              one-cycle pulse: registered /RD went 1 -> 0
//     evt_a13_o          A13 from the same registered sample as the event
//     evt_not_a13_o      /A13 from the same registered sample as the event
module famiclone_detect_ctrl_sampler (
  input  logic m2,
  input  logic reset,
  input  logic rd_i,
  input  logic a13_i,
  input  logic not_a13_i,
  output logic evt_o,
  output logic evt_a13_o,
  output logic evt_not_a13_o
);

  logic rd_q, rd_prev_q, a13_q, not_a13_q;

  // The /RD flops reset to 0, so a /RD held low across reset release cannot
  // produce a falling edge.
  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      rd_q      <= 1'b0;
      rd_prev_q <= 1'b0;
      a13_q     <= 1'b0;
      not_a13_q <= 1'b0;
    end else begin
      rd_q      <= rd_i;
      rd_prev_q <= rd_q;
      a13_q     <= a13_i;
      not_a13_q <= not_a13_i;
    end
  end

  assign evt_o         = rd_prev_q & ~rd_q;
  assign evt_a13_o     = a13_q;
  assign evt_not_a13_o = not_a13_q;

endmodule

// File: rtl/famiclone_detect_ctrl.sv
// famiclone_detect_ctrl
//   Power-on sequencer and classic/new-famiclone detector on the PPU side.
//   While the console powers up, it grounds CIRAM /CE and /A13. It then samples
//   PPU read cycles and decides whether /A13 is the true inverse of A13.
//   Ports:
//     m2, reset   CPU M2 clock and asynchronous active-high reset
//     bus         detector-side pads, controls and status (see the interface file)
module famiclone_detect_ctrl
  import famiclone_detect_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = FD_HOLD_CYCLES_DEF,
  parameter int SETTLE_CYCLES = FD_SETTLE_CYCLES_DEF,
  parameter int VOTES_LOW     = FD_VOTES_LOW_DEF,
  parameter int VOTES_HIGH    = FD_VOTES_HIGH_DEF,
  parameter int MISMATCH_MIN  = FD_MISMATCH_MIN_DEF
) (
  input logic                    m2,
  input logic                    reset,
  famiclone_detect_ctrl_if.slave bus
);

  localparam int CYC_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CW = fd_cnt_w(CYC_MAX);
  localparam int LW = fd_cnt_w(VOTES_LOW);
  localparam int HW = fd_cnt_w(VOTES_HIGH);
  localparam int MW = fd_cnt_w(MISMATCH_MIN);

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  // This value is unused when SETTLE_CYCLES=0, because SETTLE is then skipped.
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] VL_C        = LW'(VOTES_LOW);
  localparam logic [HW-1:0] VH_C        = HW'(VOTES_HIGH);
  localparam logic [MW-1:0] MM_C        = MW'(MISMATCH_MIN);

  fd_state_e     state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [LW-1:0] lo_q, lo_d;
  logic [HW-1:0] hi_q, hi_d;
  logic [MW-1:0] mm_q, mm_d;

  logic evt, evt_a13, evt_not_a13;

  famiclone_detect_ctrl_sampler u_sampler (
    .m2            (m2),
    .reset         (reset),
    .rd_i          (bus.ppu_rd_in),
    .a13_i         (bus.ppu_a13_in),
    .not_a13_i     (bus.ppu_not_a13_in),
    .evt_o         (evt),
    .evt_a13_o     (evt_a13),
    .evt_not_a13_o (evt_not_a13)
  );

  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      state_q <= FD_HOLD;
      cyc_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      mm_q    <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mm_q    <= mm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mm_d    = mm_q;
    case (state_q)
      FD_HOLD: begin
        if (cyc_q == HOLD_LAST) begin
          cyc_d   = '0;
          state_d = (SETTLE_CYCLES == 0) ? FD_SAMPLE : FD_SETTLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      FD_SETTLE: begin
        if (cyc_q == SETTLE_LAST) begin
          cyc_d   = '0;
          state_d = FD_SAMPLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      FD_SAMPLE: begin
        if (evt) begin
          // A13 equal to /A13 means /A13 is not the inverse of A13.
          if (evt_a13 == evt_not_a13) begin
            if (mm_q != MM_C) mm_d = mm_q + MW'(1);
          end else if (evt_a13) begin
            if (hi_q != VH_C) hi_d = hi_q + HW'(1);
          end else begin
            if (lo_q != VL_C) lo_d = lo_q + LW'(1);
          end
        end
        // The decision uses the updated counts. The mismatch check comes
        // first, so it wins when both conditions hold on the same edge.
        if (mm_d == MM_C)                      state_d = FD_NEWDENDY;
        else if (lo_d == VL_C && hi_d == VH_C) state_d = FD_CLASSIC;
      end
      default: ; // CLASSIC and NEWDENDY are terminal.
    endcase
    if (bus.restart) begin
      state_d = FD_HOLD;
      cyc_d   = '0;
      lo_d    = '0;
      hi_d    = '0;
      mm_d    = '0;
    end
  end

  logic ce_oe, ce_out, na13_drv, new_dendy, done;

  // The pad outputs are a function of the registered state. ciram_ce_out also
  // depends combinationally on the live A13 pad and on ext_ntram_access.
  always_comb begin
    ce_oe     = 1'b1;
    ce_out    = bus.ext_ntram_access ? 1'b1 : ~bus.ppu_a13_in;
    na13_drv  = 1'b0;
    new_dendy = 1'b0;
    done      = 1'b0;
    case (state_q)
      FD_HOLD: begin
        na13_drv = 1'b1;
        ce_out   = 1'b0;
      end
      FD_CLASSIC: done = 1'b1;
      FD_NEWDENDY: begin
        ce_oe     = 1'b0;
        ce_out    = 1'b0;
        new_dendy = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ciram_ce_oe   = ce_oe;
  assign bus.ciram_ce_out  = ce_out;
  assign bus.not_a13_drive = na13_drv;
  assign bus.new_dendy     = new_dendy;
  assign bus.detect_done   = done;
  assign bus.state_dbg     = state_q;

endmodule
